// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and stage-count derivation for the segmented pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEG   = 4;

  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SEG-bit ripple segment; exposes the carry into its top bit for overflow.
module adder_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Segmented ripple adder, one SEG-bit segment per stage, with valid/ready flow control.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
  end

  logic advance;

  // st_* are the inputs seen by stage k; r_* are the registers stage k loads.
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_acc [STAGES];
  logic             st_c   [STAGES];
  logic             st_v   [STAGES];

  logic [WIDTH-1:0] r_a    [STAGES];
  logic [WIDTH-1:0] r_b    [STAGES];
  logic [WIDTH-1:0] r_acc  [STAGES];
  logic             r_c    [STAGES];
  logic             r_v    [STAGES];
  logic             r_ovf;

  logic [SEG-1:0]   seg_s  [STAGES];
  logic             seg_co [STAGES];
  logic             seg_cm [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is folded in at the entry: invert B and force the carry-in.
  always_comb begin
    st_a[0]   = a;
    st_b[0]   = sub ? ~b : b;
    st_c[0]   = sub | cin;
    st_v[0]   = in_valid;
    st_acc[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = r_a[k-1];
      st_b[k]   = r_b[k-1];
      st_c[k]   = r_c[k-1];
      st_v[k]   = r_v[k-1];
      st_acc[k] = r_acc[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(.SEG(SEG)) u_slice (
      .a     (st_a[k][SEG-1:0]),
      .b     (st_b[k][SEG-1:0]),
      .cin   (st_c[k]),
      .s     (seg_s[k]),
      .cout  (seg_co[k]),
      .c_msb (seg_cm[k])
    );
  end

  // Operands shift down one segment per stage; finished sum segments enter
  // from the top, so the full result lines up at the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]   <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_acc[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= st_v[k];
        if (st_v[k]) begin
          r_a[k]   <= st_a[k] >> SEG;
          r_b[k]   <= st_b[k] >> SEG;
          r_c[k]   <= seg_co[k];
          r_acc[k] <= (st_acc[k] >> SEG) | (WIDTH'(seg_s[k]) << (WIDTH - SEG));
        end
      end
      if (st_v[STAGES-1]) begin
        r_ovf <= seg_cm[STAGES-1] ^ seg_co[STAGES-1];
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_acc[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule
